// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the pixel pipeline.
// Generates pix_x/pix_y, hsync/vsync, display_on and a once-per-frame strobe,
// and owns the per-frame horizontal scroll offset.
// Optional feature macro: VGA_SCROLL_EN (x_offset advances by scroll_speed each frame).
// Without it x_offset is tied to zero and pause/scroll_speed are ignored.
module vga_timing_gen #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       pause,
   input  logic [3:0] scroll_speed,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       frame_start,
   output logic [9:0] x_offset
);

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned SUM_W   = CNT_W + 1;
   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   // Counters are 10 bits wide; larger rasters cannot be represented.
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             de_q, de_d;
   logic             fs_q, fs_d;
   logic             h_last_c;
   logic             v_last_c;
   logic             wrap_c;

   // Next raster position; a disabled cycle holds position, deferring any wrap.
   always_comb begin
      h_d      = h_q;
      v_d      = v_q;
      h_last_c = (h_q == H_LAST);
      v_last_c = (v_q == V_LAST);
      wrap_c   = ena & h_last_c & v_last_c;
      if (ena) begin
         if (h_last_c) begin
            h_d = '0;
            v_d = v_last_c ? '0 : v_q + CNT_W'(1);
         end else begin
            h_d = h_q + CNT_W'(1);
         end
      end
   end

   // Decode the next position so the registered flags line up with pix_x/pix_y.
   always_comb begin
      hsync_d = ~SYNC_POL;
      vsync_d = ~SYNC_POL;
      de_d    = 1'b0;
      fs_d    = wrap_c;
      if (h_d >= HS_START && h_d <= HS_END) hsync_d = SYNC_POL;
      if (v_d >= VS_START && v_d <= VS_END) vsync_d = SYNC_POL;
      if (h_d < H_VIS && v_d < V_VIS)       de_d    = 1'b1;
   end

   // Raster state and decoded timing flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q     <= '0;
         v_q     <= '0;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         de_q    <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         h_q     <= h_d;
         v_q     <= v_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         fs_q    <= fs_d;
      end
   end

   assign pix_x       = h_q;
   assign pix_y       = v_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = de_q;
   assign frame_start = fs_q;

`ifdef VGA_SCROLL_EN
   logic [CNT_W-1:0] xo_q, xo_d;
   logic [SUM_W-1:0] sum_c;

   // Advance the scroll offset once per frame, modulo the visible width.
   always_comb begin
      xo_d  = xo_q;
      sum_c = SUM_W'(xo_q) + SUM_W'(scroll_speed);
      if (wrap_c && !pause) begin
         if (sum_c >= SUM_W'(H_DISPLAY)) begin
            xo_d = CNT_W'(sum_c - SUM_W'(H_DISPLAY));
         end else begin
            xo_d = sum_c[CNT_W-1:0];
         end
      end
   end

   // Scroll offset register; changes only on the frame-wrap edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xo_q <= '0;
      end else begin
         xo_q <= xo_d;
      end
   end

   assign x_offset = xo_q;
`else
   logic unused_scroll;

   // Scroll disabled: offset fixed at zero, scroll controls have no effect.
   assign unused_scroll = ^{pause, scroll_speed};
   assign x_offset      = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen.
// Instance u_big uses the 640x480 timing for line-level checks; u_small uses a
// 25x15 raster (16x8 visible) so frame wraps are reached in few cycles.
module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       pause = 1'b0;
   logic [3:0] scroll_speed = 4'd5;

   logic [9:0] b_x, b_y, b_xo;
   logic       b_hs, b_vs, b_de, b_fs;
   logic [9:0] s_x, s_y, s_xo;
   logic       s_hs, s_vs, s_de, s_fs;

   int chk_cnt  = 0;
   int pass_cnt = 0;

`ifdef VGA_SCROLL_EN
   localparam int XO_F1 = 5;
   localparam int XO_F2 = 10;
   localparam int XO_F3 = 15;
   localparam int XO_F4 = 14;
   localparam int XO_F6 = 14;
   localparam int XO_D  = 3;
`else
   localparam int XO_F1 = 0;
   localparam int XO_F2 = 0;
   localparam int XO_F3 = 0;
   localparam int XO_F4 = 0;
   localparam int XO_F6 = 0;
   localparam int XO_D  = 0;
`endif

   always #5 clk = ~clk;

   vga_timing_gen u_big (
      .clk(clk), .rst_n(rst_n), .ena(ena), .pause(pause), .scroll_speed(scroll_speed),
      .pix_x(b_x), .pix_y(b_y), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
      .frame_start(b_fs), .x_offset(b_xo)
   );

   vga_timing_gen #(
      .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
      .V_DISPLAY(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .ena(ena), .pause(pause), .scroll_speed(scroll_speed),
      .pix_x(s_x), .pix_y(s_y), .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
      .frame_start(s_fs), .x_offset(s_xo)
   );

   // Count one comparison and report it if it does not match.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ena   = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference scroll step for the small raster (16 visible columns).
   function automatic int scroll_next(input int xo, input int spd, input logic pz);
      int s;
      if (pz) return xo;
      s = xo + spd;
      return (s >= 16) ? s - 16 : s;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pos_err, hs_cnt, hs_first, hs_last, de_cnt, fs_cnt, vs_cnt, xo_err, fs_err, err;
      int fs_first, fs_second, p, xo_exp;

      // ---- reset values ----
      #12;
      check("rst_x", b_x, 0);
      check("rst_y", b_y, 0);
      check("rst_hs", b_hs, 1);
      check("rst_vs", b_vs, 1);
      check("rst_de", b_de, 1);
      check("rst_fs", b_fs, 0);
      check("rst_xo", b_xo, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- one full line on the 640x480 instance ----
      pos_err = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; fs_cnt = 0;
      for (int i = 0; i < 800; i++) begin
         if (b_x !== 10'(i) || b_y !== 10'd0) pos_err++;
         if (!b_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = i;
            hs_last = i;
         end
         if (b_de) de_cnt++;
         if (b_fs) fs_cnt++;
         if (b_x == 10'd640) check("de_at_640_0", b_de, 0);
         tick();
      end
      check("line_pos", pos_err, 0);
      check("hs_width", hs_cnt, 96);
      check("hs_first", hs_first, 656);
      check("hs_last", hs_last, 751);
      check("line_de", de_cnt, 640);
      check("line_fs", fs_cnt, 0);
      check("wrap_x", b_x, 0);
      check("wrap_y", b_y, 1);

      // ---- frames on the small raster, with scrolling ----
      do_reset();
      scroll_speed = 4'd5;
      pause        = 1'b0;
      pos_err = 0; xo_err = 0; fs_err = 0; fs_cnt = 0; vs_cnt = 0; hs_cnt = 0; de_cnt = 0;
      fs_first = -1; fs_second = -1; xo_exp = 0;
      for (int t = 1; t <= 2260; t++) begin
         tick();
         p = t % 375;
`ifdef VGA_SCROLL_EN
         if (p == 0) xo_exp = scroll_next(xo_exp, int'(scroll_speed), pause);
`endif
         if (s_x !== 10'(p % 25) || s_y !== 10'(p / 25)) pos_err++;
         if (s_xo !== 10'(xo_exp)) xo_err++;
         if (s_fs !== (p == 0)) fs_err++;
         if (s_fs) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = t;
            else if (fs_second < 0) fs_second = t;
         end
         if (t <= 750) begin
            if (!s_vs) vs_cnt++;
            if (!s_hs) hs_cnt++;
            if (s_de)  de_cnt++;
         end
         if (t < 25  && s_x == 10'd16 && s_y == 10'd0) check("de_at_16_0", s_de, 0);
         if (t < 375 && s_x == 10'd0  && s_y == 10'd8) check("de_at_0_8", s_de, 0);
         if (t == 374)  check("xo_in_frame", s_xo, 0);
         if (t == 375)  check("xo_frame1", s_xo, XO_F1);
         if (t == 750)  check("xo_frame2", s_xo, XO_F2);
         if (t == 1125) check("xo_frame3", s_xo, XO_F3);
         if (t == 1500) check("xo_wrap", s_xo, XO_F4);
         if (t == 2250) check("xo_paused", s_xo, XO_F6);
         if (t == 1200) scroll_speed = 4'd15;
         if (t == 1600) pause = 1'b1;
      end
      check("frame_pos", pos_err, 0);
      check("frame_xo", xo_err, 0);
      check("frame_fs_seq", fs_err, 0);
      check("fs_count", fs_cnt, 6);
      check("fs_first", fs_first, 375);
      check("fs_gap", fs_second - fs_first, 375);
      check("vs_low_2frames", vs_cnt, 100);
      check("hs_low_2frames", hs_cnt, 120);
      check("de_2frames", de_cnt, 256);
      check("big_xo", b_xo, 0);

      // ---- ena low mid-line holds everything ----
      do_reset();
      pause = 1'b0;
      repeat (300) tick();
      check("ena_pre_x", b_x, 300);
      ena = 1'b0;
      err = 0;
      repeat (100) begin
         tick();
         if (b_x !== 10'd300 || b_y !== 10'd0 || b_fs !== 1'b0 || b_hs !== 1'b1 || b_de !== 1'b1)
            err++;
      end
      check("ena_hold", err, 0);
      ena = 1'b1;
      tick();
      check("ena_resume_x", b_x, 301);

      // ---- wrap deferred while ena is low ----
      do_reset();
      scroll_speed = 4'd3;
      pause        = 1'b0;
      repeat (374) tick();
      check("defer_pre_x", s_x, 24);
      check("defer_pre_y", s_y, 14);
      ena = 1'b0;
      err = 0;
      repeat (10) begin
         tick();
         if (s_x !== 10'd24 || s_y !== 10'd14 || s_fs !== 1'b0 || s_xo !== 10'd0) err++;
      end
      check("defer_hold", err, 0);
      ena = 1'b1;
      tick();
      check("defer_x", s_x, 0);
      check("defer_y", s_y, 0);
      check("defer_fs", s_fs, 1);
      check("defer_xo", s_xo, XO_D);
      tick();
      check("defer_fs_drop", s_fs, 0);
      check("defer_next_x", s_x, 1);

      // ---- asynchronous reset between clock edges ----
      do_reset();
      repeat (260) tick();
      check("pre_arst_vs", s_vs, 0);
      check("pre_arst_x", b_x, 260);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_bx", b_x, 0);
      check("arst_by", b_y, 0);
      check("arst_sx", s_x, 0);
      check("arst_sy", s_y, 0);
      check("arst_vs", s_vs, 1);
      check("arst_hs", s_hs, 1);
      check("arst_de", s_de, 1);
      check("arst_fs", s_fs, 0);
      check("arst_xo", s_xo, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
